// File: rtl/averager_scheduler_if.sv
// Host and averager signals of the acquisition scheduler, bundled for one port.
// master drives the host/averager inputs; slave is the scheduler itself.
interface averager_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32
);
    logic                start;
    logic                stop;
    logic                ack;
    logic                continuous;
    logic [31-WIDTH:0]   n_target;
    logic [CNT_W-1:0]    timeout;
    logic                avg_ready;
    logic [31-WIDTH:0]   avg_n_avg;
    logic                avg_restart;
    logic                avg_off;
    logic                busy;
    logic                done;
    logic                timed_out;
    logic [CNT_W-1:0]    acq_count;

    modport master (
        output start, stop, ack, continuous, n_target, timeout, avg_ready, avg_n_avg,
        input  avg_restart, avg_off, busy, done, timed_out, acq_count
    );

    modport slave (
        input  start, stop, ack, continuous, n_target, timeout, avg_ready, avg_n_avg,
        output avg_restart, avg_off, busy, done, timed_out, acq_count
    );
endinterface

// File: rtl/averager_scheduler.sv
// Acquisition scheduler: restarts the averager, waits for n_target periods or a timeout.
// All outputs registered, one cycle after the deciding input; no backpressure, stop aborts anywhere.
module averager_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    averager_scheduler_if.slave  sif
);
    localparam int NW = 32 - WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_TMO
    } state_e;

    state_e            state_q;
    logic [NW-1:0]     n_target_q;
    logic [CNT_W-1:0]  timeout_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [CNT_W-1:0]  acq_count_q;
    logic              avg_restart_q;
    logic              avg_off_q;
    logic              busy_q;
    logic              done_q;
    logic              timed_out_q;

    logic [NW-1:0]     n_need;
    logic              complete;
    logic              expire;
    logic              arm_d;

    assign n_need   = (n_target_q == '0) ? NW'(1) : n_target_q;
    assign complete = sif.avg_ready && (sif.avg_n_avg >= n_need);
    assign expire   = (timeout_q != '0) && (tmo_cnt_q == timeout_q - CNT_W'(1));

    // Entering ARM this edge: host start from an idle state, or auto re-arm on ack.
    assign arm_d = !sif.stop &&
                   ((((state_q == S_IDLE) || (state_q == S_TMO)) && sif.start) ||
                    ((state_q == S_DONE) && sif.ack && sif.continuous));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            n_target_q    <= '0;
            timeout_q     <= '0;
            tmo_cnt_q     <= '0;
            acq_count_q   <= '0;
            avg_restart_q <= 1'b0;
            avg_off_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            avg_restart_q <= 1'b0;
            if (sif.stop) begin
                state_q   <= S_IDLE;
                avg_off_q <= 1'b1;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else if (arm_d) begin
                state_q       <= S_ARM;
                n_target_q    <= sif.n_target;
                timeout_q     <= sif.timeout;
                tmo_cnt_q     <= '0;
                avg_restart_q <= 1'b1;
                avg_off_q     <= 1'b0;
                busy_q        <= 1'b1;
                done_q        <= 1'b0;
                timed_out_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_ARM: state_q <= S_RUN;
                    S_RUN: begin
                        // Completion outranks a timeout expiring on the same edge.
                        if (complete) begin
                            state_q     <= S_DONE;
                            avg_off_q   <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            acq_count_q <= acq_count_q + CNT_W'(1);
                        end else if (expire) begin
                            state_q     <= S_TMO;
                            avg_off_q   <= 1'b1;
                            busy_q      <= 1'b0;
                            timed_out_q <= 1'b1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (sif.ack) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sif.avg_restart = avg_restart_q;
    assign sif.avg_off     = avg_off_q;
    assign sif.busy        = busy_q;
    assign sif.done        = done_q;
    assign sif.timed_out   = timed_out_q;
    assign sif.acq_count   = acq_count_q;
endmodule

// File: tb/tb_averager_scheduler.sv
// Scenario bench for averager_scheduler; inputs change and outputs are sampled on the falling edge.
module tb_averager_scheduler;
    localparam int WIDTH = 8;
    localparam int CNT_W = 32;
    localparam int NW    = 32 - WIDTH;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_acq = 0;

    averager_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif();

    averager_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        sif.start      = 1'b0;
        sif.stop       = 1'b0;
        sif.ack        = 1'b0;
        sif.avg_ready  = 1'b0;
        sif.avg_n_avg  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet_inputs();
        sif.continuous = 1'b0;
        sif.n_target   = NW'(1);
        sif.timeout    = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (sif.avg_restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %0b want 0", sif.avg_restart); end
        checks++; if (sif.avg_off !== 1'b1) begin errors++; $display("FAIL reset_avg_off got %0b want 1", sif.avg_off); end
        checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", sif.busy); end
        checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", sif.done); end
        checks++; if (sif.timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out got %0b want 0", sif.timed_out); end
        checks++; if (sif.acq_count !== 32'd0) begin errors++; $display("FAIL reset_acq_count got %0d want 0", sif.acq_count); end
    endtask

    // Ready every 256 cycles with n_avg 1..4; an ack in RUN must be ignored.
    task automatic test_basic();
        int pulses = 0;
        sif.n_target = NW'(4);
        sif.timeout  = '0;
        sif.start    = 1'b1;
        tick();
        sif.start = 1'b0;
        checks++; if (sif.avg_restart !== 1'b1 || sif.busy !== 1'b1 || sif.avg_off !== 1'b0)
            begin errors++; $display("FAIL basic_arm got restart=%0b busy=%0b off=%0b want 1 1 0", sif.avg_restart, sif.busy, sif.avg_off); end
        for (int k = 1; k <= 4; k++) begin
            for (int c = 0; c < 255; c++) begin
                sif.ack       = (k == 2 && c == 10);
                sif.avg_n_avg = NW'($urandom);
                tick();
                if (sif.avg_restart) pulses++;
            end
            sif.ack = 1'b0;
            checks++; if (sif.busy !== 1'b1 || sif.done !== 1'b0)
                begin errors++; $display("FAIL basic_waiting_%0d got busy=%0b done=%0b want 1 0", k, sif.busy, sif.done); end
            sif.avg_ready = 1'b1;
            sif.avg_n_avg = NW'(k);
            tick();
            sif.avg_ready = 1'b0;
            if (sif.avg_restart) pulses++;
        end
        exp_acq++;
        checks++; if (pulses != 0) begin errors++; $display("FAIL basic_extra_restart got %0d want 0", pulses); end
        checks++; if (sif.done !== 1'b1 || sif.busy !== 1'b0 || sif.avg_off !== 1'b1)
            begin errors++; $display("FAIL basic_done got done=%0b busy=%0b off=%0b want 1 0 1", sif.done, sif.busy, sif.avg_off); end
        checks++; if (sif.acq_count !== 32'(exp_acq)) begin errors++; $display("FAIL basic_acq_count got %0d want %0d", sif.acq_count, exp_acq); end
    endtask

    // Starts from DONE; three acks with continuous=1 each re-arm one cycle later.
    task automatic test_continuous();
        int pulses = 0;
        for (int r = 0; r < 3; r++) begin
            sif.continuous = 1'b1;
            sif.ack        = 1'b1;
            tick();
            sif.ack        = 1'b0;
            sif.continuous = 1'(($urandom));
            if (sif.avg_restart) pulses++;
            checks++; if (sif.avg_restart !== 1'b1 || sif.done !== 1'b0 || sif.busy !== 1'b1)
                begin errors++; $display("FAIL cont_rearm_%0d got restart=%0b done=%0b busy=%0b want 1 0 1", r, sif.avg_restart, sif.done, sif.busy); end
            tick();
            if (sif.avg_restart) pulses++;
            for (int g = 0; g < int'($urandom_range(0, 6)); g++) begin
                sif.avg_n_avg = NW'($urandom);
                tick();
                if (sif.avg_restart) pulses++;
            end
            sif.avg_ready = 1'b1;
            sif.avg_n_avg = NW'($urandom_range(4, 255));
            tick();
            sif.avg_ready = 1'b0;
            exp_acq++;
            checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL cont_done_%0d got %0b want 1", r, sif.done); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL cont_pulses got %0d want 3", pulses); end
        checks++; if (sif.acq_count !== 32'd4) begin errors++; $display("FAIL cont_acq_count got %0d want 4", sif.acq_count); end
        sif.continuous = 1'b0;
        sif.ack        = 1'b1;
        tick();
        sif.ack = 1'b0;
        checks++; if (sif.done !== 1'b0 || sif.busy !== 1'b0 || sif.avg_off !== 1'b1 || sif.avg_restart !== 1'b0)
            begin errors++; $display("FAIL cont_to_idle got done=%0b busy=%0b off=%0b restart=%0b want 0 0 1 0", sif.done, sif.busy, sif.avg_off, sif.avg_restart); end
    endtask

    // timeout=100 allows 100 RUN cycles; busy lasts the ARM cycle plus those 100.
    task automatic test_timeout();
        int busy_cycles = 0;
        sif.n_target = NW'(5);
        sif.timeout  = 32'd100;
        sif.start    = 1'b1;
        tick();
        sif.start   = 1'b0;
        sif.timeout = 32'd3;
        while (sif.busy === 1'b1 && busy_cycles < 300) begin
            tick();
            busy_cycles++;
        end
        checks++; if (busy_cycles != 101) begin errors++; $display("FAIL tmo_length got %0d want 101", busy_cycles); end
        checks++; if (sif.timed_out !== 1'b1 || sif.done !== 1'b0 || sif.avg_off !== 1'b1)
            begin errors++; $display("FAIL tmo_flags got tmo=%0b done=%0b off=%0b want 1 0 1", sif.timed_out, sif.done, sif.avg_off); end
        tick();
        tick();
        checks++; if (sif.timed_out !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0b want 1", sif.timed_out); end
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        checks++; if (sif.timed_out !== 1'b1 || sif.busy !== 1'b0) begin errors++; $display("FAIL tmo_stop_keeps got tmo=%0b busy=%0b want 1 0", sif.timed_out, sif.busy); end
        sif.timeout = '0;
        sif.start   = 1'b1;
        tick();
        sif.start = 1'b0;
        checks++; if (sif.timed_out !== 1'b0 || sif.avg_restart !== 1'b1)
            begin errors++; $display("FAIL tmo_restart got tmo=%0b restart=%0b want 0 1", sif.timed_out, sif.avg_restart); end
        tick();
        tick();
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        checks++; if (sif.busy !== 1'b0 || sif.avg_off !== 1'b1 || sif.acq_count !== 32'(exp_acq))
            begin errors++; $display("FAIL stop_in_run got busy=%0b off=%0b acq=%0d want 0 1 %0d", sif.busy, sif.avg_off, sif.acq_count, exp_acq); end
    endtask

    task automatic test_collision();
        sif.n_target = NW'(2);
        sif.timeout  = 32'd10;
        sif.start    = 1'b1;
        tick();
        sif.start = 1'b0;
        tick();
        for (int j = 0; j < 9; j++) tick();
        checks++; if (sif.busy !== 1'b1) begin errors++; $display("FAIL coll_prewait got busy=%0b want 1", sif.busy); end
        sif.avg_ready = 1'b1;
        sif.avg_n_avg = NW'(2);
        tick();
        sif.avg_ready = 1'b0;
        exp_acq++;
        checks++; if (sif.done !== 1'b1 || sif.timed_out !== 1'b0)
            begin errors++; $display("FAIL coll_done_wins got done=%0b tmo=%0b want 1 0", sif.done, sif.timed_out); end
        sif.ack = 1'b1;
        tick();
        sif.ack   = 1'b0;
        sif.start = 1'b1;
        sif.stop  = 1'b1;
        tick();
        sif.start = 1'b0;
        sif.stop  = 1'b0;
        checks++; if (sif.avg_restart !== 1'b0 || sif.busy !== 1'b0)
            begin errors++; $display("FAIL start_stop_together got restart=%0b busy=%0b want 0 0", sif.avg_restart, sif.busy); end
    endtask

    task automatic test_edge_values();
        sif.n_target = '0;
        sif.timeout  = '0;
        sif.start    = 1'b1;
        tick();
        sif.start = 1'b0;
        tick();
        sif.avg_ready = 1'b1;
        sif.avg_n_avg = '0;
        tick();
        checks++; if (sif.busy !== 1'b1) begin errors++; $display("FAIL ntarget0_zero_count got busy=%0b want 1", sif.busy); end
        sif.avg_n_avg = NW'(1);
        tick();
        sif.avg_ready = 1'b0;
        exp_acq++;
        checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL ntarget0_done got %0b want 1", sif.done); end
        sif.ack = 1'b1;
        tick();
        sif.ack      = 1'b0;
        sif.n_target = NW'(3);
        sif.start    = 1'b1;
        tick();
        sif.start    = 1'b0;
        sif.n_target = NW'(1);
        tick();
        sif.avg_n_avg = NW'(255);
        tick();
        for (int v = 1; v <= 2; v++) begin
            sif.avg_ready = 1'b1;
            sif.avg_n_avg = NW'(v);
            tick();
            checks++; if (sif.busy !== 1'b1 || sif.done !== 1'b0)
                begin errors++; $display("FAIL midrun_ntarget_%0d got busy=%0b done=%0b want 1 0", v, sif.busy, sif.done); end
        end
        sif.avg_n_avg = NW'(3);
        tick();
        sif.avg_ready = 1'b0;
        exp_acq++;
        checks++; if (sif.done !== 1'b1 || sif.acq_count !== 32'(exp_acq))
            begin errors++; $display("FAIL midrun_done got done=%0b acq=%0d want 1 %0d", sif.done, sif.acq_count, exp_acq); end
        sif.ack = 1'b1;
        tick();
        sif.ack = 1'b0;
    endtask

    // Random targets, timeouts and ready patterns against a first-event model.
    task automatic test_random();
        int rdy[64];
        int val[64];
        int n, to, need, comp, exp_end, ended;
        bit exp_done;
        for (int it = 0; it < 25; it++) begin
            n  = $urandom_range(0, 7);
            to = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            for (int j = 0; j < 64; j++) begin
                rdy[j] = ($urandom_range(0, 3) == 0) ? 1 : 0;
                val[j] = $urandom_range(0, 9);
            end
            rdy[63] = 1;
            val[63] = 255;
            need = (n == 0) ? 1 : n;
            comp = -1;
            for (int j = 0; j < 64; j++)
                if (comp < 0 && rdy[j] == 1 && val[j] >= need) comp = j;
            exp_done = !(to != 0 && to - 1 < comp);
            exp_end  = exp_done ? comp : to - 1;
            sif.n_target = NW'(n);
            sif.timeout  = 32'(to);
            sif.start    = 1'b1;
            tick();
            sif.start = 1'b0;
            tick();
            ended = -1;
            for (int j = 0; j < 64 && ended < 0; j++) begin
                sif.avg_ready = rdy[j][0];
                sif.avg_n_avg = (rdy[j] == 1) ? NW'(val[j]) : NW'($urandom);
                sif.n_target  = NW'($urandom_range(0, 2));
                sif.timeout   = 32'($urandom_range(1, 3));
                tick();
                if (sif.busy === 1'b0) ended = j;
            end
            sif.avg_ready = 1'b0;
            if (exp_done) exp_acq++;
            checks++; if (ended != exp_end) begin errors++; $display("FAIL rand_end_%0d got %0d want %0d", it, ended, exp_end); end
            checks++; if (sif.done !== exp_done || sif.timed_out !== !exp_done)
                begin errors++; $display("FAIL rand_outcome_%0d got done=%0b tmo=%0b want %0b %0b", it, sif.done, sif.timed_out, exp_done, !exp_done); end
            checks++; if (sif.acq_count !== 32'(exp_acq)) begin errors++; $display("FAIL rand_acq_%0d got %0d want %0d", it, sif.acq_count, exp_acq); end
            if (exp_done) begin
                sif.ack = 1'b1;
                tick();
                sif.ack = 1'b0;
            end
        end
    endtask

    task automatic test_reset_in_arm();
        sif.n_target = NW'(2);
        sif.timeout  = '0;
        sif.start    = 1'b1;
        tick();
        checks++; if (sif.avg_restart !== 1'b1) begin errors++; $display("FAIL rstarm_pre got restart=%0b want 1", sif.avg_restart); end
        rst     = 1'b1;
        sif.ack = 1'b1;
        tick();
        rst       = 1'b0;
        sif.start = 1'b0;
        sif.ack   = 1'b0;
        exp_acq   = 0;
        checks++; if (sif.avg_restart !== 1'b0 || sif.avg_off !== 1'b1 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.timed_out !== 1'b0)
            begin errors++; $display("FAIL rstarm_outputs got restart=%0b off=%0b busy=%0b done=%0b tmo=%0b want 0 1 0 0 0",
                sif.avg_restart, sif.avg_off, sif.busy, sif.done, sif.timed_out); end
        checks++; if (sif.acq_count !== 32'd0) begin errors++; $display("FAIL rstarm_acq got %0d want 0", sif.acq_count); end
        tick();
        checks++; if (sif.busy !== 1'b0 || sif.avg_restart !== 1'b0) begin errors++; $display("FAIL rstarm_stays_idle got busy=%0b restart=%0b want 0 0", sif.busy, sif.avg_restart); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_continuous();
        test_timeout();
        test_collision();
        test_edge_values();
        test_random();
        test_reset_in_arm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
